beep_melody_seq: RTL
====================

Name: beep_melody_seq

Overview:
Melody sequencer that drives the shared PWM tone generator feeding the buzzer. It steps through a fixed song table, one note at a time. For each note it supplies the PWM period (counter_arr), compare value (counter_ccr) and count enable, and times note and inter-note gap lengths. Start/stop/loop control comes from the key-debounce logic; busy/done feed the LED/status logic.

Parameters:
BEAT_CYCLES, 12_500_000, clk cycles per beat (250 ms at 50 MHz)
GAP_CYCLES, 1_250_000, silent cycles at end of every note; must be >= 1 and < BEAT_CYCLES
SONG_LEN, 16, number of table entries played (1..32)
VOL_SHIFT, 1, counter_ccr = counter_arr >> VOL_SHIFT (1 = 50 % duty)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins playback from entry 0 when idle
stop  in  1  level/pulse; aborts playback
loop  in  1  sampled at end of last note; 1 = restart at entry 0
counter_arr  out  32  PWM period count for current note
counter_ccr  out  32  PWM compare count
pwm_en  out  1  PWM count enable; 0 = silent
busy  out  1  1 in any state except IDLE
done  out  1  one-cycle pulse on normal song completion
note_idx  out  5  current table index

Behaviour:
- Reset (async, rst=1): state IDLE; counter_arr=0, counter_ccr=0, pwm_en=0, busy=0, done=0, note_idx=0; all internal counters 0.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE: start=1 at edge k -> LOAD at k+1, note_idx=0, busy=1 from k+1.
- Start while busy is ignored.
- LOAD (exactly 1 cycle): register the table entry for note_idx into counter_arr and counter_ccr. pwm_en=1 unless the entry is a rest. Note cycle counter cleared. Next state PLAY.
- PLAY lasts beats*BEAT_CYCLES - GAP_CYCLES cycles, then GAP.
- GAP lasts GAP_CYCLES cycles with pwm_en=0 and counter_arr/ccr held.
- End of GAP, note_idx < SONG_LEN-1: note_idx+1, go to LOAD.
- End of GAP, note_idx = SONG_LEN-1, loop=1: note_idx=0, go to LOAD, no done pulse.
- End of GAP, note_idx = SONG_LEN-1, loop=0: go to DONE.
- DONE (1 cycle): done=1, pwm_en=0; then IDLE with note_idx=0 and busy=0.
- stop=1 in any non-IDLE state: next state IDLE, pwm_en=0, note_idx=0, no done pulse. counter_arr/ccr keep their last value.
- stop has priority over start and over any end-of-note transition in the same cycle.
- Table entry format, 6 bits: pitch[3:0], dur[1:0]; beats = dur+1 (1..4).
- Pitch codes 1..7 give low-octave periods 191130, 170241, 151698, 143183, 127550, 113635, 101234.
- Pitch codes 9..15 give the same periods >>1 (middle octave).
- Pitch codes 0 and 8 are rests: counter_arr=0 and pwm_en=0 for the whole note.
- Note counter width is clog2(4*BEAT_CYCLES); it never wraps within a note.
- Latency: start edge -> pwm_en=1 two edges later for a non-rest first note.

Decomposition:
- Package beep_pkg holds the pitch-period constants (L1..L7), rest codes, the state enum and the entry field widths/positions.
- Sub-module beep_song_rom: combinational index(5) -> entry(6) lookup holding the song, padded with rests up to 32 entries.

Test Plan (BEAT_CYCLES=10, GAP_CYCLES=2, SONG_LEN=4, song = {pitch1 dur0, pitch0 dur1, pitch9 dur0, pitch7 dur3}):
- Pulse start -> busy at +1 edge, pwm_en=1 and counter_arr=191130, counter_ccr=95565 at +2 edge; pwm_en high 8 cycles, low 2 cycles.
- Entry 1 (rest, 2 beats) -> counter_arr=0, pwm_en=0 for all 20 cycles; entry 2 -> counter_arr=95565 for 8 cycles.
- loop=0 through the whole song -> done high exactly 1 cycle after entry 3's gap; total start-to-done = 4 LOAD + 80 note cycles + 1; then busy=0.
- loop=1 at end of entry 3 -> note_idx returns to 0, LOAD, counter_arr=191130 again, done never asserts.
- stop in mid-PLAY of entry 2, asserted together with start -> next cycle IDLE, pwm_en=0, busy=0, no done; a later start replays from entry 0.
- Assert rst mid-GAP (asynchronous, between edges) -> all outputs 0 immediately; a start after release behaves as in scenario 1.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared constants for the buzzer melody sequencer: pitch periods, song entry layout, FSM encodings.
package beep_pkg;

  localparam int IDX_W     = 5;
  localparam int PITCH_W   = 4;
  localparam int DUR_W     = 2;
  localparam int ENTRY_W   = PITCH_W + DUR_W;
  localparam int PITCH_LSB = DUR_W;
  localparam int DUR_LSB   = 0;

  // Low-octave PWM periods in 50 MHz clk counts
  localparam logic [31:0] L1 = 32'd191130;
  localparam logic [31:0] L2 = 32'd170241;
  localparam logic [31:0] L3 = 32'd151698;
  localparam logic [31:0] L4 = 32'd143183;
  localparam logic [31:0] L5 = 32'd127550;
  localparam logic [31:0] L6 = 32'd113635;
  localparam logic [31:0] L7 = 32'd101234;

  localparam logic [PITCH_W-1:0] REST_LO = 4'd0;
  localparam logic [PITCH_W-1:0] REST_HI = 4'd8;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_PLAY = 3'd2;
  localparam state_t ST_GAP  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [PITCH_W-1:0] pitch,
                                                 input logic [DUR_W-1:0] dur);
    return {pitch, dur};
  endfunction

  // Bit 3 of the pitch code selects the octave above (half period)
  function automatic logic [31:0] pitch_period(input logic [PITCH_W-1:0] pitch);
    logic [31:0] p;
    case (pitch[2:0])
      3'd1:    p = L1;
      3'd2:    p = L2;
      3'd3:    p = L3;
      3'd4:    p = L4;
      3'd5:    p = L5;
      3'd6:    p = L6;
      3'd7:    p = L7;
      default: p = 32'd0;
    endcase
    return pitch[3] ? (p >> 1) : p;
  endfunction

  function automatic logic is_rest(input logic [PITCH_W-1:0] pitch);
    return (pitch == REST_LO) || (pitch == REST_HI);
  endfunction

endpackage

// File: rtl/beep_song_rom.sv
// Combinational song table: 5-bit index to {pitch, dur} entry, zero latency, no flow control.
// Entries past the tune are rests so any SONG_LEN up to 32 stays silent beyond the melody.
module beep_song_rom
  import beep_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [ENTRY_W-1:0] entry
);

  always_comb begin
    entry = mk_entry(REST_LO, 2'd0);
    case (idx)
      5'd0:    entry = mk_entry(4'd1,  2'd0);
      5'd1:    entry = mk_entry(4'd0,  2'd1);
      5'd2:    entry = mk_entry(4'd9,  2'd0);
      5'd3:    entry = mk_entry(4'd7,  2'd3);
      5'd4:    entry = mk_entry(4'd9,  2'd0);
      5'd5:    entry = mk_entry(4'd10, 2'd0);
      5'd6:    entry = mk_entry(4'd11, 2'd1);
      5'd7:    entry = mk_entry(4'd0,  2'd0);
      5'd8:    entry = mk_entry(4'd12, 2'd0);
      5'd9:    entry = mk_entry(4'd11, 2'd0);
      5'd10:   entry = mk_entry(4'd10, 2'd1);
      5'd11:   entry = mk_entry(4'd8,  2'd0);
      5'd12:   entry = mk_entry(4'd13, 2'd0);
      5'd13:   entry = mk_entry(4'd12, 2'd0);
      5'd14:   entry = mk_entry(4'd11, 2'd0);
      5'd15:   entry = mk_entry(4'd9,  2'd3);
      default: entry = mk_entry(REST_LO, 2'd0);
    endcase
  end

endmodule

// File: rtl/beep_melody_seq.sv
// Steps the song table driving PWM period/compare/enable; first tone two edges after start.
// No backpressure: stop aborts immediately, start is ignored while busy.
module beep_melody_seq
  import beep_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int SONG_LEN    = 16,
  parameter int VOL_SHIFT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  output logic [31:0] counter_arr,
  output logic [31:0] counter_ccr,
  output logic        pwm_en,
  output logic        busy,
  output logic        done,
  output logic [4:0]  note_idx
);

  localparam int CW = $clog2(4 * BEAT_CYCLES);
  localparam logic [CW-1:0]    GAP_C    = CW'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DUR_W-1:0]      dur_q;
  logic [CW-1:0]         note_last;
  logic [CW-1:0]         play_last;
  logic [ENTRY_W-1:0]    entry;
  logic [PITCH_W-1:0]    pitch;
  logic [31:0]           period;

  beep_song_rom u_rom (
    .idx   (note_idx),
    .entry (entry)
  );

  assign pitch  = entry[PITCH_LSB +: PITCH_W];
  assign period = pitch_period(pitch);
  assign busy   = (state != ST_IDLE);

  // One counter spans the whole note; the tone stops GAP_CYCLES before its end
  always_comb begin
    case (dur_q)
      2'd0:    note_last = CW'(1 * BEAT_CYCLES - 1);
      2'd1:    note_last = CW'(2 * BEAT_CYCLES - 1);
      2'd2:    note_last = CW'(3 * BEAT_CYCLES - 1);
      default: note_last = CW'(4 * BEAT_CYCLES - 1);
    endcase
    play_last = note_last - GAP_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dur_q       <= '0;
      counter_arr <= '0;
      counter_ccr <= '0;
      pwm_en      <= 1'b0;
      done        <= 1'b0;
      note_idx    <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != ST_IDLE) begin
        state    <= ST_IDLE;
        pwm_en   <= 1'b0;
        note_idx <= '0;
        cnt      <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop) begin
              state    <= ST_LOAD;
              note_idx <= '0;
            end
          end
          ST_LOAD: begin
            counter_arr <= period;
            counter_ccr <= period >> VOL_SHIFT;
            pwm_en      <= !is_rest(pitch);
            dur_q       <= entry[DUR_LSB +: DUR_W];
            cnt         <= '0;
            state       <= ST_PLAY;
          end
          ST_PLAY: begin
            cnt <= cnt + 1'b1;
            if (cnt == play_last) begin
              state  <= ST_GAP;
              pwm_en <= 1'b0;
            end
          end
          ST_GAP: begin
            if (cnt == note_last) begin
              cnt <= '0;
              if (note_idx != LAST_IDX) begin
                note_idx <= note_idx + 1'b1;
                state    <= ST_LOAD;
              end else if (loop) begin
                note_idx <= '0;
                state    <= ST_LOAD;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DONE: begin
            state    <= ST_IDLE;
            pwm_en   <= 1'b0;
            note_idx <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
